// File: rtl/ring_code_checker.sv
`default_nettype none
// ============================================================================
// Module   : ring_code_checker
// Brief    : One-hot ring counter decoder with sequence lock and error monitor.
// Revision : 1.0 - initial release
// ============================================================================
module ring_code_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 2,
    parameter int ERR_W    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sample_en,
    input  logic [WIDTH-1:0]         ring_in,
    input  logic                     dir,
    output logic [$clog2(WIDTH)-1:0] index,
    output logic                     onehot_ok,
    output logic                     locked,
    output logic                     seq_err,
    output logic [ERR_W-1:0]         err_count
);

    localparam int IDX_W   = $clog2(WIDTH);
    localparam int CNT_RAW = $clog2(LOCK_CNT + 1);
    localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;

    localparam logic [IDX_W-1:0] c_last     = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_lock_cnt = CNT_W'(LOCK_CNT);
    localparam logic [WIDTH-1:0] c_one      = {{(WIDTH-1){1'b0}}, 1'b1};

    localparam logic [1:0] S_SEARCH  = 2'd0;
    localparam logic [1:0] S_ACQUIRE = 2'd1;
    localparam logic [1:0] S_LOCKED  = 2'd2;

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_index;
    logic             r_onehot_ok;
    logic             r_seq_err;
    logic [ERR_W-1:0] r_err_count;
    logic [CNT_W-1:0] r_good_cnt;

    logic [1:0]       w_state_nxt;
    logic [IDX_W-1:0] w_index_nxt;
    logic             w_onehot_nxt;
    logic             w_seq_err_nxt;
    logic [ERR_W-1:0] w_err_nxt;
    logic [CNT_W-1:0] w_good_nxt;

    logic             w_valid;
    logic [IDX_W-1:0] w_enc;
    logic [IDX_W-1:0] w_expected;
    logic [CNT_W-1:0] w_good_inc;
    logic             w_match;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign w_valid = (ring_in != '0) && ((ring_in & (ring_in - c_one)) == '0);

    always_comb begin
        w_enc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (ring_in[i]) begin
                w_enc = IDX_W'(i);
            end
        end
    end

    always_comb begin
        if (dir) begin
            w_expected = (r_index == '0) ? c_last : r_index - 1'b1;
        end else begin
            w_expected = (r_index == c_last) ? '0 : r_index + 1'b1;
        end
    end

    assign w_match    = w_valid && (w_enc == w_expected);
    assign w_good_inc = r_good_cnt + 1'b1;

    always_comb begin
        w_state_nxt   = r_state;
        w_index_nxt   = r_index;
        w_onehot_nxt  = r_onehot_ok;
        w_seq_err_nxt = 1'b0;
        w_err_nxt     = r_err_count;
        w_good_nxt    = r_good_cnt;
        if (sample_en) begin
            w_onehot_nxt = w_valid;
            case (r_state)
                S_SEARCH: begin
                    if (w_valid) begin
                        w_index_nxt = w_enc;
                        w_good_nxt  = '0;
                        w_state_nxt = S_ACQUIRE;
                    end
                end
                S_ACQUIRE: begin
                    if (w_match) begin
                        w_index_nxt = w_enc;
                        if (w_good_inc == c_lock_cnt) begin
                            w_good_nxt  = '0;
                            w_state_nxt = S_LOCKED;
                        end else begin
                            w_good_nxt = w_good_inc;
                        end
                    end else if (w_valid) begin
                        w_index_nxt = w_enc;
                        w_good_nxt  = '0;
                    end else begin
                        w_good_nxt  = '0;
                        w_state_nxt = S_SEARCH;
                    end
                end
                S_LOCKED: begin
                    if (w_match) begin
                        w_index_nxt = w_enc;
                    end else begin
                        // A wrong-but-valid word still tells us where the ring is now.
                        if (w_valid) begin
                            w_index_nxt = w_enc;
                        end
                        w_seq_err_nxt = 1'b1;
                        if (r_err_count != '1) begin
                            w_err_nxt = r_err_count + 1'b1;
                        end
                        w_good_nxt  = '0;
                        w_state_nxt = S_SEARCH;
                    end
                end
                default: begin
                    w_good_nxt  = '0;
                    w_state_nxt = S_SEARCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_SEARCH;
            r_index     <= '0;
            r_onehot_ok <= 1'b0;
            r_seq_err   <= 1'b0;
            r_err_count <= '0;
            r_good_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_index     <= w_index_nxt;
            r_onehot_ok <= w_onehot_nxt;
            r_seq_err   <= w_seq_err_nxt;
            r_err_count <= w_err_nxt;
            r_good_cnt  <= w_good_nxt;
        end
    end

    assign index     = r_index;
    assign onehot_ok = r_onehot_ok;
    assign locked    = (r_state == S_LOCKED);
    assign seq_err   = r_seq_err;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_ring_code_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_ring_code_checker
// Brief    : Directed self-checking bench for ring_code_checker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ring_code_checker;

    logic       clk;
    logic       reset;
    logic       sample_en;
    logic [3:0] ring_in;
    logic       dir;
    logic [1:0] index;
    logic       onehot_ok;
    logic       locked;
    logic       seq_err;
    logic [7:0] err_count;

    logic       reset2;
    logic       sample_en2;
    logic [3:0] ring_in2;
    logic       dir2;
    logic [1:0] index2;
    logic       onehot_ok2;
    logic       locked2;
    logic       seq_err2;
    logic [1:0] err_count2;

    int n_checks;
    int n_fail;

    ring_code_checker #(.WIDTH(4), .LOCK_CNT(2), .ERR_W(8)) dut (
        .clk(clk), .reset(reset), .sample_en(sample_en), .ring_in(ring_in), .dir(dir),
        .index(index), .onehot_ok(onehot_ok), .locked(locked), .seq_err(seq_err),
        .err_count(err_count)
    );

    ring_code_checker #(.WIDTH(4), .LOCK_CNT(2), .ERR_W(2)) dut2 (
        .clk(clk), .reset(reset2), .sample_en(sample_en2), .ring_in(ring_in2), .dir(dir2),
        .index(index2), .onehot_ok(onehot_ok2), .locked(locked2), .seq_err(seq_err2),
        .err_count(err_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus at the falling edge; return 1 time unit after the rising edge.
    task automatic drive(input logic en, input logic [3:0] w, input logic d);
        @(negedge clk);
        sample_en = en;
        ring_in   = w;
        dir       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input logic en, input logic [3:0] w);
        @(negedge clk);
        sample_en2 = en;
        ring_in2   = w;
        dir2       = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1; reset2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({index, onehot_ok, locked, seq_err, err_count} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_state: got idx=%0d ok=%b lk=%b se=%b err=%0d, want all 0",
                     index, onehot_ok, locked, seq_err, err_count);
        end
        n_checks++;
        if ({index2, onehot_ok2, locked2, seq_err2, err_count2} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_state2: got idx=%0d ok=%b lk=%b se=%b err=%0d, want all 0",
                     index2, onehot_ok2, locked2, seq_err2, err_count2);
        end
        @(negedge clk);
        reset = 1'b0; reset2 = 1'b0;
    endtask

    // Check a sampled sequence against expected index/lock, with no errors expected.
    task automatic run_clean(input string name, input logic d, input logic [3:0] w [5],
                             input logic [1:0] ei [5], input logic el [5]);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, w[i], d);
            n_checks++;
            if (index !== ei[i] || locked !== el[i] || onehot_ok !== 1'b1 ||
                seq_err !== 1'b0 || err_count !== 8'd0) begin
                n_fail++;
                $display("FAIL %s[%0d]: got idx=%0d lk=%b ok=%b se=%b err=%0d, want idx=%0d lk=%b ok=1 se=0 err=0",
                         name, i, index, locked, onehot_ok, seq_err, err_count, ei[i], el[i]);
            end
        end
    endtask

    task automatic test_rotate_up;
        logic [3:0] w [5]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [1:0] ei [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic       el [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        run_clean("rotate_up", 1'b0, w, ei, el);
    endtask

    task automatic test_invalid_break;
        drive(1'b1, 4'b0010, 1'b0);
        drive(1'b1, 4'b0100, 1'b0);
        n_checks++;
        if (index !== 2'd2 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL invalid_pre: got idx=%0d lk=%b, want idx=2 lk=1", index, locked);
        end
        drive(1'b1, 4'b0110, 1'b0);
        n_checks++;
        if (onehot_ok !== 1'b0 || seq_err !== 1'b1 || err_count !== 8'd1 ||
            locked !== 1'b0 || index !== 2'd2) begin
            n_fail++;
            $display("FAIL invalid_break: got ok=%b se=%b err=%0d lk=%b idx=%0d, want ok=0 se=1 err=1 lk=0 idx=2",
                     onehot_ok, seq_err, err_count, locked, index);
        end
        drive(1'b0, 4'b0000, 1'b0);
        n_checks++;
        if (seq_err !== 1'b0 || err_count !== 8'd1) begin
            n_fail++;
            $display("FAIL invalid_pulse: got se=%b err=%0d, want se=0 err=1", seq_err, err_count);
        end
    endtask

    task automatic test_skip;
        logic [3:0] w  [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001,
                               4'b0100, 4'b1000, 4'b0001};
        logic [1:0] ei [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3, 2'd0};
        logic       el [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       es [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] ee [8] = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, w[i], 1'b0);
            n_checks++;
            if (index !== ei[i] || locked !== el[i] || seq_err !== es[i] || err_count !== ee[i]) begin
                n_fail++;
                $display("FAIL skip[%0d]: got idx=%0d lk=%b se=%b err=%0d, want idx=%0d lk=%b se=%b err=%0d",
                         i, index, locked, seq_err, err_count, ei[i], el[i], es[i], ee[i]);
            end
        end
        // Relock after the break: SEARCH loads 1000, then two correct steps.
        drive(1'b1, 4'b0010, 1'b0);
        n_checks++;
        if (index !== 2'd1 || locked !== 1'b1 || seq_err !== 1'b0 || err_count !== 8'd2) begin
            n_fail++;
            $display("FAIL skip_relock: got idx=%0d lk=%b se=%b err=%0d, want idx=1 lk=1 se=0 err=2",
                     index, locked, seq_err, err_count);
        end
    endtask

    task automatic test_rotate_down;
        logic [3:0] w [5]  = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
        logic [1:0] ei [5] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
        logic       el [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_clean("rotate_down", 1'b1, w, ei, el);
    endtask

    task automatic test_hold_and_reset;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, (i % 2 == 0) ? 4'b0000 : 4'b1111, i[0]);
            n_checks++;
            if (index !== 2'd3 || onehot_ok !== 1'b1 || locked !== 1'b1 ||
                seq_err !== 1'b0 || err_count !== 8'd0) begin
                n_fail++;
                $display("FAIL hold[%0d]: got idx=%0d ok=%b lk=%b se=%b err=%0d, want idx=3 ok=1 lk=1 se=0 err=0",
                         i, index, onehot_ok, locked, seq_err, err_count);
            end
        end
        // Reset must win over a correct, enabled sample.
        @(negedge clk);
        reset     = 1'b1;
        sample_en = 1'b1;
        ring_in   = 4'b0100;
        dir       = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({index, onehot_ok, locked, seq_err, err_count} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_locked: got idx=%0d ok=%b lk=%b se=%b err=%0d, want all 0",
                     index, onehot_ok, locked, seq_err, err_count);
        end
        @(negedge clk);
        reset     = 1'b0;
        sample_en = 1'b0;
    endtask

    task automatic test_saturate;
        logic [1:0] ee [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int k = 0; k < 5; k++) begin
            drive2(1'b1, 4'b0001);
            drive2(1'b1, 4'b0010);
            drive2(1'b1, 4'b0100);
            n_checks++;
            if (locked2 !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_lock[%0d]: got lk=%b, want lk=1", k, locked2);
            end
            drive2(1'b1, 4'b0000);
            n_checks++;
            if (err_count2 !== ee[k] || seq_err2 !== 1'b1 || locked2 !== 1'b0) begin
                n_fail++;
                $display("FAIL sat_err[%0d]: got err=%0d se=%b lk=%b, want err=%0d se=1 lk=0",
                         k, err_count2, seq_err2, locked2, ee[k]);
            end
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        reset2     = 1'b1;
        sample_en  = 1'b0;
        ring_in    = 4'b0000;
        dir        = 1'b0;
        sample_en2 = 1'b0;
        ring_in2   = 4'b0000;
        dir2       = 1'b0;

        test_reset();
        test_rotate_up();
        test_invalid_break();
        test_skip();
        test_rotate_down();
        test_hold_and_reset();
        test_saturate();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
